uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a selectable divisor table, an input synchronizer and
// single-cycle Rx_Done / Rx_Error pulses. Async active-low reset on rst.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_rate_select,
  input  logic       Rx_Serial,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Done,
  output logic       Rx_Error,
  output logic       Rx_Active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic                   rx_prev;
  logic                   start_det;

  logic [10:0] div, div_n;
  logic [10:0] sel_div;
  logic [10:0] div_m1;
  logic [10:0] half_m1;
  logic [10:0] clk_count, clk_count_n;
  logic [2:0]  bit_index, bit_index_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  rx_byte_q, rx_byte_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  // Synchronizer and edge-detect flops idle high so reset never looks like a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], Rx_Serial};
      rx_prev <= rx_sync;
    end
  end

  assign rx_sync   = sync_q[SYNC_STAGES-1];
  assign start_det = rx_prev & ~rx_sync;

  always_comb begin
    sel_div = 11'd1042;
    case (baud_rate_select)
      3'b000:  sel_div = 11'd1042;
      3'b001:  sel_div = 11'd695;
      3'b010:  sel_div = 11'd521;
      3'b011:  sel_div = 11'd261;
      3'b100:  sel_div = 11'd174;
      3'b101:  sel_div = 11'd87;
      3'b110:  sel_div = 11'd79;
      3'b111:  sel_div = 11'd39;
      default: sel_div = 11'd1042;
    endcase
  end

  assign div_m1  = div - 11'd1;
  assign half_m1 = (div >> 1) - 11'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div       <= 11'd1042;
      clk_count <= '0;
      bit_index <= '0;
      shift     <= '0;
      rx_byte_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= div_n;
      clk_count <= clk_count_n;
      bit_index <= bit_index_n;
      shift     <= shift_n;
      rx_byte_q <= rx_byte_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    div_n       = div;
    clk_count_n = clk_count;
    bit_index_n = bit_index;
    shift_n     = shift;
    rx_byte_n   = rx_byte_q;
    done_n      = 1'b0;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        clk_count_n = '0;
        bit_index_n = '0;
        if (start_det) begin
          state_n = START;
          div_n   = sel_div;
        end
      end
      START: begin
        if (clk_count >= half_m1) begin
          clk_count_n = '0;
          state_n     = rx_sync ? IDLE : DATA;
        end else begin
          clk_count_n = clk_count + 11'd1;
        end
      end
      DATA: begin
        if (clk_count >= div_m1) begin
          clk_count_n        = '0;
          shift_n[bit_index] = rx_sync;
          if (bit_index == 3'd7) begin
            bit_index_n = '0;
            state_n     = STOP;
          end else begin
            bit_index_n = bit_index + 3'd1;
          end
        end else begin
          clk_count_n = clk_count + 11'd1;
        end
      end
      STOP: begin
        if (clk_count >= div_m1) begin
          clk_count_n = '0;
          state_n     = CLEANUP;
          if (rx_sync) begin
            rx_byte_n = shift;
            done_n    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          clk_count_n = clk_count + 11'd1;
        end
      end
      CLEANUP: begin
        clk_count_n = '0;
        bit_index_n = '0;
        // An edge seen in this cycle would be lost by the IDLE hop, so take it here.
        if (start_det) begin
          state_n = START;
          div_n   = sel_div;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n     = IDLE;
        clk_count_n = '0;
        bit_index_n = '0;
      end
    endcase
  end

  assign Rx_Byte   = rx_byte_q;
  assign Rx_Done   = done_q;
  assign Rx_Error  = err_q;
  assign Rx_Active = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized serial
// traffic at every divisor, compared against a byte-level expectation queue.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] baud_rate_select;
  logic       Rx_Serial;
  logic [7:0] Rx_Byte;
  logic       Rx_Done;
  logic       Rx_Error;
  logic       Rx_Active;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .baud_rate_select (baud_rate_select),
    .Rx_Serial        (Rx_Serial),
    .Rx_Byte          (Rx_Byte),
    .Rx_Done          (Rx_Done),
    .Rx_Error         (Rx_Error),
    .Rx_Active        (Rx_Active)
  );

  always #5 clk = ~clk;

  int unsigned div_tab [8] = '{1042, 695, 521, 261, 174, 87, 79, 39};

  int n_cmp = 0;
  int n_bad = 0;

  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;
  int n_wide = 0;
  int n_act  = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  always @(negedge clk) begin
    if (Rx_Done) begin
      n_done <= n_done + 1;
      rx_q.push_back(Rx_Byte);
    end
    if (Rx_Error)             n_err  <= n_err + 1;
    if (Rx_Done && Rx_Error)  n_both <= n_both + 1;
    if ((Rx_Done && prev_done) || (Rx_Error && prev_err)) n_wide <= n_wide + 1;
    if (Rx_Active)            n_act  <= n_act + 1;
    prev_done <= Rx_Done;
    prev_err  <= Rx_Error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; optionally scrambles the select after the start edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int unsigned sel, input bit scramble);
    int unsigned d;
    d = div_tab[sel];
    baud_rate_select = 3'(sel);
    Rx_Serial = 1'b0;
    if (scramble) begin
      idle(6);
      baud_rate_select = 3'($urandom);
      idle(d - 6);
    end else begin
      idle(d);
    end
    for (int i = 0; i < 8; i++) begin
      Rx_Serial = b[i];
      idle(d);
    end
    Rx_Serial = stop_ok;
    idle(d);
    if (stop_ok) begin
      exp_q.push_back(b);
      last_good = b;
    end
    baud_rate_select = 3'(sel);
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0, e0, a0, nb;
    logic [7:0] b;
    rst = 1'b0;
    Rx_Serial = 1'b1;
    baud_rate_select = 3'b111;
    last_good = 8'h00;
    idle(5);
    check("rst_byte",   Rx_Byte,   8'h00);
    check("rst_done",   Rx_Done,   1'b0);
    check("rst_error",  Rx_Error,  1'b0);
    check("rst_active", Rx_Active, 1'b0);
    rst = 1'b1;
    idle(10);

    // Clean frame at 39 clocks per bit
    d0 = n_done; e0 = n_err;
    send_frame(8'hA5, 1'b1, 7, 1'b0);
    idle(80);
    check("a5_done",  n_done - d0, 1);
    check("a5_error", n_err - e0,  0);
    check("a5_rxbyte", Rx_Byte, 8'hA5);
    drain("a5");

    // Framing error, then line held low: no restart until it goes high and falls again
    d0 = n_done; e0 = n_err;
    send_frame(8'h3C, 1'b0, 7, 1'b0);
    idle(120);
    check("ferr_active_low_line", Rx_Active, 1'b0);
    Rx_Serial = 1'b1;
    idle(80);
    check("ferr_error", n_err - e0,  1);
    check("ferr_done",  n_done - d0, 0);
    check("ferr_rxbyte", Rx_Byte, last_good);

    // Short glitch: START lasts half a bit then falls back to IDLE
    d0 = n_done; e0 = n_err; a0 = n_act;
    Rx_Serial = 1'b0;
    idle(10);
    Rx_Serial = 1'b1;
    idle(80);
    check("glitch_active_cycles", n_act - a0, div_tab[7] / 2);
    check("glitch_done",  n_done - d0, 0);
    check("glitch_error", n_err - e0,  0);

    // Back-to-back frames at the slowest rate
    d0 = n_done; e0 = n_err;
    send_frame(8'h00, 1'b1, 0, 1'b0);
    send_frame(8'hFF, 1'b1, 0, 1'b0);
    idle(2 * div_tab[0]);
    check("b2b_done",  n_done - d0, 2);
    check("b2b_error", n_err - e0,  0);
    drain("b2b");

    // Reset in the middle of data bit 3, then a fresh frame
    d0 = n_done; e0 = n_err;
    baud_rate_select = 3'b101;
    b = 8'h3C;
    Rx_Serial = 1'b0;
    idle(div_tab[5]);
    for (int i = 0; i < 3; i++) begin
      Rx_Serial = b[i];
      idle(div_tab[5]);
    end
    Rx_Serial = b[3];
    idle(40);
    check("midrst_active_before", Rx_Active, 1'b1);
    rst = 1'b0;
    Rx_Serial = 1'b1;
    idle(3);
    check("midrst_byte",   Rx_Byte,   8'h00);
    check("midrst_done",   Rx_Done,   1'b0);
    check("midrst_error",  Rx_Error,  1'b0);
    check("midrst_active", Rx_Active, 1'b0);
    rst = 1'b1;
    last_good = 8'h00;
    idle(2 * div_tab[5]);
    check("midrst_no_pulse", (n_done - d0) + (n_err - e0), 0);
    send_frame(8'h5A, 1'b1, 5, 1'b0);
    idle(2 * div_tab[5]);
    check("after_rst_done", n_done - d0, 1);
    check("after_rst_error", n_err - e0, 0);
    check("after_rst_rxbyte", Rx_Byte, 8'h5A);
    drain("after_rst");

    // Random traffic at every select, select scrambled mid-frame
    for (int s = 0; s < 8; s++) begin
      nb = (s < 3) ? 1 : ((s == 3) ? 2 : 4);
      d0 = n_done; e0 = n_err;
      for (int k = 0; k < nb; k++)
        send_frame(8'($urandom), 1'b1, s, 1'b1);
      idle(2 * div_tab[s]);
      check($sformatf("rand_sel%0d_done", s),  n_done - d0, nb);
      check($sformatf("rand_sel%0d_error", s), n_err - e0,  0);
      check($sformatf("rand_sel%0d_rxbyte", s), Rx_Byte, last_good);
      drain($sformatf("rand_sel%0d", s));
    end

    check("done_and_error_together", n_both, 0);
    check("pulse_wider_than_one", n_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
